// File: rtl/lcd_frac_clkdiv.sv
// lcd_frac_clkdiv: fractional clock-enable generator for the LCD pixel path.
// A first-order phase accumulator emits a single-cycle clk_en strobe at an
// average rate of NUM/DEN per hclkin cycle. Ratio updates are handshaked in,
// held pending, and applied only on a period boundary so no runt period occurs.
// Optional macro LCD_FRAC_CLKDIV_CLKDIV_OUT_EN builds the near-50% clk_div
// level; without it clk_div is tied low.
module lcd_frac_clkdiv #(
    parameter int ACC_W   = 16,
    parameter int DEF_NUM = 2,
    parameter int DEF_DEN = 7
) (
    input  logic             hclkin,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [ACC_W-1:0] cfg_num,
    input  logic [ACC_W-1:0] cfg_den,
    output logic             cfg_ready,
    output logic             cfg_applied,
    output logic             cfg_err,
    output logic             clk_en,
    output logic             clk_div
);

    // A ratio is usable only when 0 < num <= den (which also excludes den = 0).
    function automatic logic ratio_legal(input logic [ACC_W-1:0] n, input logic [ACC_W-1:0] d);
        return (n != '0) && (n <= d);
    endfunction

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] num_q, num_d;
    logic [ACC_W-1:0] den_q, den_d;
    logic [ACC_W-1:0] pnum_q, pnum_d;
    logic [ACC_W-1:0] pden_q, pden_d;
    logic             pend_q, pend_d;
    logic             clk_en_q, clk_en_d;
    logic             applied_q, applied_d;
    logic             err_q, err_d;

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_wrap;
    logic             strobe;
    logic             xfer;
    logic             apply;

    // Accumulator step, handshake decode and apply-point selection.
    always_comb begin
        acc_d     = acc_q;
        num_d     = num_q;
        den_d     = den_q;
        pnum_d    = pnum_q;
        pden_d    = pden_q;
        pend_d    = pend_q;
        // One extra bit keeps acc + num exact; the wrapped value always fits
        // back in ACC_W bits because it is strictly below den.
        sum       = {1'b0, acc_q} + {1'b0, num_q};
        acc_wrap  = acc_q + num_q - den_q;
        strobe    = enable && (sum >= {1'b0, den_q});
        xfer      = cfg_valid && !pend_q;
        // pend_q is the registered flag, so a ratio accepted on a strobe
        // cycle waits for the following boundary.
        apply     = pend_q && (strobe || !enable);
        clk_en_d  = strobe;
        applied_d = apply;
        err_d     = xfer && !ratio_legal(cfg_num, cfg_den);

        if (!enable) begin
            acc_d = '0;
        end else if (strobe) begin
            acc_d = acc_wrap;
        end else begin
            acc_d = sum[ACC_W-1:0];
        end

        if (apply) begin
            num_d  = pnum_q;
            den_d  = pden_q;
            acc_d  = '0;
            pend_d = 1'b0;
        end

        if (xfer && ratio_legal(cfg_num, cfg_den)) begin
            pend_d = 1'b1;
            pnum_d = cfg_num;
            pden_d = cfg_den;
        end
    end

    // State and registered outputs; reset drops any pending ratio.
    always_ff @(posedge hclkin) begin
        if (reset) begin
            acc_q     <= '0;
            num_q     <= ACC_W'(DEF_NUM);
            den_q     <= ACC_W'(DEF_DEN);
            pnum_q    <= '0;
            pden_q    <= '0;
            pend_q    <= 1'b0;
            clk_en_q  <= 1'b0;
            applied_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            num_q     <= num_d;
            den_q     <= den_d;
            pnum_q    <= pnum_d;
            pden_q    <= pden_d;
            pend_q    <= pend_d;
            clk_en_q  <= clk_en_d;
            applied_q <= applied_d;
            err_q     <= err_d;
        end
    end

    assign cfg_ready   = !pend_q;
    assign cfg_applied = applied_q;
    assign cfg_err     = err_q;
    assign clk_en      = clk_en_q;

`ifdef LCD_FRAC_CLKDIV_CLKDIV_OUT_EN
    logic             clk_div_q, clk_div_d;
    logic [ACC_W:0]   half_den;

    // Divided level: high while the upcoming phase sits in the lower half of the period.
    always_comb begin
        half_den  = ({1'b0, den_d} + {{ACC_W{1'b0}}, 1'b1}) >> 1;
        clk_div_d = enable && ({1'b0, acc_d} < half_den);
    end

    // Register the divided level alongside clk_en.
    always_ff @(posedge hclkin) begin
        if (reset) begin
            clk_div_q <= 1'b0;
        end else begin
            clk_div_q <= clk_div_d;
        end
    end

    assign clk_div = clk_div_q;
`else
    assign clk_div = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_frac_clkdiv.sv
// Testbench for lcd_frac_clkdiv: directed scenarios plus randomized traffic,
// checked against a reference model that tracks the phase as edge count k
// since the last restart (strobe when floor(k*n/d) steps up).
module tb_lcd_frac_clkdiv;

    localparam int ACC_W = 16;

    logic             hclkin = 1'b0;
    logic             reset;
    logic             enable;
    logic             cfg_valid;
    logic [ACC_W-1:0] cfg_num;
    logic [ACC_W-1:0] cfg_den;
    logic             cfg_ready;
    logic             cfg_applied;
    logic             cfg_err;
    logic             clk_en;
    logic             clk_div;

    int tests = 0;
    int fails = 0;

    // Reference model state
    longint m_k;
    longint m_n, m_d, m_pn, m_pd;
    bit     m_pend;

    lcd_frac_clkdiv #(.ACC_W(ACC_W), .DEF_NUM(2), .DEF_DEN(7)) dut (
        .hclkin     (hclkin),
        .reset      (reset),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_num    (cfg_num),
        .cfg_den    (cfg_den),
        .cfg_ready  (cfg_ready),
        .cfg_applied(cfg_applied),
        .cfg_err    (cfg_err),
        .clk_en     (clk_en),
        .clk_div    (clk_div)
    );

    always #5 hclkin = ~hclkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit will_strobe();
        return (((m_k + 1) * m_n) / m_d) != ((m_k * m_n) / m_d);
    endfunction

    // One clock: predict from the model, advance the DUT, compare all outputs.
    task automatic step();
        bit     xfer, legal, strobe, apply;
        logic   e_en, e_app, e_err, e_div;
        longint accn;
        if (reset) begin
            m_n = 2; m_d = 7; m_k = 0; m_pend = 0;
            e_en = 0; e_app = 0; e_err = 0; e_div = 0;
        end else begin
            xfer   = cfg_valid && !m_pend;
            legal  = (cfg_num != 0) && (cfg_num <= cfg_den);
            e_err  = xfer && !legal;
            strobe = 0;
            if (enable) begin
                strobe = will_strobe();
                m_k++;
            end else begin
                m_k = 0;
            end
            apply = m_pend && (strobe || !enable);
            e_en  = strobe;
            e_app = apply;
            if (apply) begin
                m_n = m_pn; m_d = m_pd; m_k = 0; m_pend = 0;
            end
            if (xfer && legal) begin
                m_pend = 1; m_pn = cfg_num; m_pd = cfg_den;
            end
            accn = (m_k * m_n) % m_d;
`ifdef LCD_FRAC_CLKDIV_CLKDIV_OUT_EN
            e_div = enable && (accn < (m_d + 1) / 2);
`else
            e_div = 1'b0;
`endif
        end
        @(posedge hclkin);
        #1;
        chk("clk_en", clk_en, e_en);
        chk("cfg_applied", cfg_applied, e_app);
        chk("cfg_err", cfg_err, e_err);
        chk("cfg_ready", cfg_ready, !m_pend);
        chk("clk_div", clk_div, e_div);
    endtask

    task automatic offer(input int n, input int d);
        cfg_valid = 1'b1;
        cfg_num   = ACC_W'(n);
        cfg_den   = ACC_W'(d);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        bit found;
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_num = '0; cfg_den = '0;
        m_n = 2; m_d = 7; m_k = 0; m_pend = 0; m_pn = 0; m_pd = 0;

        // Reset values
        step(); step();
        chk("rst_ready", cfg_ready, 1'b1);
        chk("rst_clk_en", clk_en, 1'b0);
        reset = 1'b0;

        // Default 2/7: strobes after edges 4, 7, 11, 14 only
        enable = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            chk("edge_pattern_2_7", clk_en, (i == 4 || i == 7 || i == 11 || i == 14));
            cnt += int'(clk_en);
        end
        chk("strobes_in_14", cnt, 4);

        // Offer 1/4 mid-stream, then every 4 cycles
        step(); step();
        offer(1, 4);
        chk("ready_low_after_offer", cfg_ready, 1'b0);
        for (int i = 0; i < 20; i++) step();

        // Illegal ratios leave 2/7 running
        reset = 1'b1; step(); reset = 1'b0;
        step(); step();
        offer(0, 5);
        chk("err_0_5", cfg_err, 1'b1);
        offer(9, 8);
        chk("err_9_8", cfg_err, 1'b1);
        chk("ready_after_err", cfg_ready, 1'b1);
        for (int i = 0; i < 14; i++) step();

        // Transfer on a strobe cycle with a second request held high
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (will_strobe()) found = 1;
            else step();
        end
        chk("found_strobe_slot", found, 1'b1);
        cfg_valid = 1'b1; cfg_num = 16'd3; cfg_den = 16'd8;
        step();
        chk("strobe_at_accept", clk_en, 1'b1);
        chk("no_apply_at_accept", cfg_applied, 1'b0);
        cfg_num = 16'd1; cfg_den = 16'd3;
        for (int i = 0; i < 24; i++) step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Divide-by-1 with enable running
        offer(5, 5);
        for (int i = 0; i < 6; i++) step();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt += int'(clk_en);
        end
        chk("div_by_1_count", cnt, 10);

        // Divide-by-1 applied while disabled
        enable = 1'b0;
        step();
        offer(3, 3);
        step();
        chk("applied_while_disabled", cfg_applied, 1'b1);
        chk("clk_en_low_disabled", clk_en, 1'b0);
        step();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Reset with a ratio pending
        offer(1, 5);
        chk("pending_before_reset", cfg_ready, 1'b0);
        reset = 1'b1; step(); reset = 1'b0;
        chk("ready_after_reset", cfg_ready, 1'b1);
        for (int i = 1; i <= 14; i++) begin
            step();
            chk("restart_pattern_2_7", clk_en, (i == 4 || i == 7 || i == 11 || i == 14));
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_den   = ACC_W'($urandom_range(1, 12));
            if ($urandom_range(0, 9) == 0) cfg_den = '0;
            cfg_num   = ACC_W'($urandom_range(0, int'(cfg_den) + 1));
            step();
        end
        reset = 1'b0; cfg_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
